ccc_lock_reset_gen: RTL and testbench

Parametrised lock-qualified reset and clock-enable generator placed directly behind a CCC/PLL instance in the fabric clock domain (GL0). It synchronises the asynchronous PLL LOCK and holds the fabric in reset until lock has been stable for a programmable time. It then produces NUM_CH independently divided clock-enable strobes. Lock loss is detected, counted and flagged sticky for firmware.

---
 rtl/ccc_lock_reset_gen.sv | 168 ++++++++++++++++
 tb/tb_ccc_lock_reset_gen.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ccc_lock_reset_gen.sv
// Lock-qualified fabric reset and clock-enable generator for the CCC GL0 domain.
// State table:  IDLE | fabric held in reset, waiting for LOCK_SYNC
//               QUALIFY | lock seen, counting down the stable-lock window
//               RUN | fabric released, clock-enable dividers active
module ccc_lock_reset_gen #(
  parameter int NUM_CH             = 2,
  parameter int DIV_W              = 8,
  parameter int LOCK_STABLE_CYCLES = 16,
  parameter int SYNC_STAGES        = 2,
  parameter int LOSS_CNT_W         = 4
) (
  input  logic                      CLK,
  input  logic                      RESET_N,
  input  logic                      LOCK,
  input  logic [NUM_CH*DIV_W-1:0]   DIV,
  input  logic                      CLR_LOSS,
  output logic                      LOCK_SYNC,
  output logic                      FABRIC_RESET_N,
  output logic [NUM_CH-1:0]         CE,
  output logic                      LOCK_LOST,
  output logic [LOSS_CNT_W-1:0]     LOSS_COUNT,
  output logic [1:0]                STATE
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUALIFY = 2'd1,
    RUN     = 2'd2
  } state_t;

  localparam int STB_W = $clog2(LOCK_STABLE_CYCLES + 1);
  // The edge that first sees LOCK_SYNC high already counts as one stable cycle.
  localparam logic [STB_W-1:0] STABLE_LOAD = STB_W'(LOCK_STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  state_t                 state_q, state_d;
  logic [STB_W-1:0]       stable_q, stable_d;
  logic                   loss_evt;
  logic                   run_d;
  logic                   frn_q;
  logic                   lost_q;
  logic [LOSS_CNT_W-1:0]  loss_cnt_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], LOCK};
    end
  end

  assign LOCK_SYNC = sync_q[SYNC_STAGES-1];

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= IDLE;
      stable_q <= '0;
    end else begin
      state_q  <= state_d;
      stable_q <= stable_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    stable_d = stable_q;
    loss_evt = 1'b0;
    case (state_q)
      IDLE: begin
        stable_d = '0;
        if (LOCK_SYNC) begin
          if (LOCK_STABLE_CYCLES == 1) begin
            state_d = RUN;
          end else begin
            state_d  = QUALIFY;
            stable_d = STABLE_LOAD;
          end
        end
      end
      QUALIFY: begin
        if (!LOCK_SYNC) begin
          state_d  = IDLE;
          stable_d = '0;
        end else if (stable_q <= STB_W'(1)) begin
          state_d  = RUN;
          stable_d = '0;
        end else begin
          stable_d = stable_q - STB_W'(1);
        end
      end
      RUN: begin
        if (!LOCK_SYNC) begin
          state_d  = IDLE;
          loss_evt = 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        stable_d = '0;
      end
    endcase
  end

  assign run_d = (state_d == RUN);
  assign STATE = state_q;

  // Registered from the next state so reset release and CE gating line up with the state change.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      frn_q <= 1'b0;
    end else begin
      frn_q <= run_d;
    end
  end

  assign FABRIC_RESET_N = frn_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DIV_W-1:0] div_raw;
    logic [DIV_W-1:0] term;
    logic [DIV_W-1:0] cnt_q;
    logic             ce_q;

    assign div_raw = DIV[i*DIV_W +: DIV_W];
    assign term    = (div_raw == '0) ? '0 : div_raw - DIV_W'(1);

    // >= rather than == so a ratio lowered below the current count wraps on the next edge.
    always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
        cnt_q <= '0;
        ce_q  <= 1'b0;
      end else if (!run_d) begin
        cnt_q <= '0;
        ce_q  <= 1'b0;
      end else if (cnt_q >= term) begin
        cnt_q <= '0;
        ce_q  <= 1'b1;
      end else begin
        cnt_q <= cnt_q + DIV_W'(1);
        ce_q  <= 1'b0;
      end
    end

    assign CE[i] = ce_q;
  end

  // A loss on the same edge as CLR_LOSS wins and restarts the count at one.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      lost_q     <= 1'b0;
      loss_cnt_q <= '0;
    end else if (loss_evt) begin
      lost_q <= 1'b1;
      if (CLR_LOSS) begin
        loss_cnt_q <= LOSS_CNT_W'(1);
      end else if (loss_cnt_q != '1) begin
        loss_cnt_q <= loss_cnt_q + LOSS_CNT_W'(1);
      end
    end else if (CLR_LOSS) begin
      lost_q     <= 1'b0;
      loss_cnt_q <= '0;
    end
  end

  assign LOCK_LOST  = lost_q;
  assign LOSS_COUNT = loss_cnt_q;

endmodule

// File: tb/tb_ccc_lock_reset_gen.sv
// Directed bench for ccc_lock_reset_gen: vector table plus hand sequences for loss, saturation and reset.
module tb_ccc_lock_reset_gen;

  logic        CLK;
  logic        RESET_N;
  logic        LOCK;
  logic [15:0] DIV;
  logic        CLR_LOSS;
  logic        LOCK_SYNC;
  logic        FABRIC_RESET_N;
  logic [1:0]  CE;
  logic        LOCK_LOST;
  logic [3:0]  LOSS_COUNT;
  logic [1:0]  STATE;

  int n_cmp = 0;
  int n_err = 0;

  ccc_lock_reset_gen dut (
    .CLK            (CLK),
    .RESET_N        (RESET_N),
    .LOCK           (LOCK),
    .DIV            (DIV),
    .CLR_LOSS       (CLR_LOSS),
    .LOCK_SYNC      (LOCK_SYNC),
    .FABRIC_RESET_N (FABRIC_RESET_N),
    .CE             (CE),
    .LOCK_LOST      (LOCK_LOST),
    .LOSS_COUNT     (LOSS_COUNT),
    .STATE          (STATE)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          n;
    logic        lock;
    logic [15:0] div;
    logic        e_sync;
    logic        e_frn;
    logic [1:0]  e_ce;
    logic [1:0]  e_st;
    logic        e_ll;
    logic [3:0]  e_lc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mkv(int n, logic lk, logic [15:0] dv, logic s, logic f,
                               logic [1:0] ce, logic [1:0] st, logic ll, logic [3:0] lc);
    vec_t v;
    v.n = n; v.lock = lk; v.div = dv; v.e_sync = s; v.e_frn = f;
    v.e_ce = ce; v.e_st = st; v.e_ll = ll; v.e_lc = lc;
    return v;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_run(input string name, input int max_cyc);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      step();
      if (STATE == 2'd2) ok = 1'b1;
    end
    chk(name, ok, 1'b1);
  endtask

  initial begin
    int exp_lc;
    RESET_N  = 1'b0;
    LOCK     = 1'b1;
    DIV      = 16'h0300;
    CLR_LOSS = 1'b0;
    step();
    step();
    chk("rst.sync",  LOCK_SYNC,      1'b0);
    chk("rst.frn",   FABRIC_RESET_N, 1'b0);
    chk("rst.ce",    CE,             2'b00);
    chk("rst.state", STATE,          2'd0);
    chk("rst.lost",  LOCK_LOST,      1'b0);
    chk("rst.cnt",   LOSS_COUNT,     4'd0);
    RESET_N = 1'b1;

    //                n   lk  div       sync frn ce     st    ll  lc
    tbl.push_back(mkv(1,  1, 16'h0300, 0, 0, 2'b00, 2'd0, 0, 0)); // e1
    tbl.push_back(mkv(1,  1, 16'h0300, 1, 0, 2'b00, 2'd0, 0, 0)); // e2
    tbl.push_back(mkv(1,  1, 16'h0300, 1, 0, 2'b00, 2'd1, 0, 0)); // e3 count 1
    tbl.push_back(mkv(9,  1, 16'h0300, 1, 0, 2'b00, 2'd1, 0, 0)); // e12 count 10
    tbl.push_back(mkv(2,  0, 16'h0300, 0, 0, 2'b00, 2'd1, 0, 0)); // e14
    tbl.push_back(mkv(1,  0, 16'h0300, 0, 0, 2'b00, 2'd0, 0, 0)); // e15 back to idle
    tbl.push_back(mkv(2,  0, 16'h0300, 0, 0, 2'b00, 2'd0, 0, 0)); // e17
    tbl.push_back(mkv(1,  1, 16'h0300, 0, 0, 2'b00, 2'd0, 0, 0)); // e18
    tbl.push_back(mkv(1,  1, 16'h0300, 1, 0, 2'b00, 2'd0, 0, 0)); // e19 sync re-rises
    tbl.push_back(mkv(1,  1, 16'h0300, 1, 0, 2'b00, 2'd1, 0, 0)); // e20
    tbl.push_back(mkv(14, 1, 16'h0300, 1, 0, 2'b00, 2'd1, 0, 0)); // e34
    tbl.push_back(mkv(1,  1, 16'h0300, 1, 1, 2'b01, 2'd2, 0, 0)); // run c1
    tbl.push_back(mkv(1,  1, 16'h0300, 1, 1, 2'b01, 2'd2, 0, 0)); // c2
    tbl.push_back(mkv(1,  1, 16'h0300, 1, 1, 2'b11, 2'd2, 0, 0)); // c3
    tbl.push_back(mkv(1,  1, 16'h0300, 1, 1, 2'b01, 2'd2, 0, 0)); // c4
    tbl.push_back(mkv(1,  1, 16'h0300, 1, 1, 2'b01, 2'd2, 0, 0)); // c5
    tbl.push_back(mkv(1,  1, 16'h0300, 1, 1, 2'b11, 2'd2, 0, 0)); // c6
    tbl.push_back(mkv(1,  1, 16'h0300, 1, 1, 2'b01, 2'd2, 0, 0)); // c7
    tbl.push_back(mkv(1,  1, 16'h0300, 1, 1, 2'b01, 2'd2, 0, 0)); // c8 count 2
    tbl.push_back(mkv(1,  1, 16'h0200, 1, 1, 2'b11, 2'd2, 0, 0)); // c9 ratio now 2
    tbl.push_back(mkv(1,  1, 16'h0200, 1, 1, 2'b01, 2'd2, 0, 0)); // c10
    tbl.push_back(mkv(1,  1, 16'h0200, 1, 1, 2'b11, 2'd2, 0, 0)); // c11
    tbl.push_back(mkv(1,  1, 16'h0200, 1, 1, 2'b01, 2'd2, 0, 0)); // c12
    tbl.push_back(mkv(1,  1, 16'h0200, 1, 1, 2'b11, 2'd2, 0, 0)); // c13
    tbl.push_back(mkv(5,  1, 16'h0800, 1, 1, 2'b01, 2'd2, 0, 0)); // c18 count 5 of 8
    tbl.push_back(mkv(1,  1, 16'h0200, 1, 1, 2'b11, 2'd2, 0, 0)); // c19 drop below count
    tbl.push_back(mkv(1,  1, 16'h0200, 1, 1, 2'b01, 2'd2, 0, 0)); // c20
    tbl.push_back(mkv(2,  0, 16'h0200, 0, 1, 2'b01, 2'd2, 0, 0)); // still run
    tbl.push_back(mkv(1,  0, 16'h0200, 0, 0, 2'b00, 2'd0, 1, 1)); // loss edge
    tbl.push_back(mkv(2,  1, 16'h0200, 1, 0, 2'b00, 2'd0, 1, 1));
    tbl.push_back(mkv(1,  1, 16'h0200, 1, 0, 2'b00, 2'd1, 1, 1));
    tbl.push_back(mkv(14, 1, 16'h0200, 1, 0, 2'b00, 2'd1, 1, 1));
    tbl.push_back(mkv(1,  1, 16'h0200, 1, 1, 2'b01, 2'd2, 1, 1)); // requalified

    for (int r = 0; r < tbl.size(); r++) begin
      LOCK = tbl[r].lock;
      DIV  = tbl[r].div;
      for (int k = 0; k < tbl[r].n; k++) step();
      chk($sformatf("row%0d.sync", r),  LOCK_SYNC,      tbl[r].e_sync);
      chk($sformatf("row%0d.frn", r),   FABRIC_RESET_N, tbl[r].e_frn);
      chk($sformatf("row%0d.ce", r),    CE,             tbl[r].e_ce);
      chk($sformatf("row%0d.state", r), STATE,          tbl[r].e_st);
      chk($sformatf("row%0d.lost", r),  LOCK_LOST,      tbl[r].e_ll);
      chk($sformatf("row%0d.cnt", r),   LOSS_COUNT,     tbl[r].e_lc);
    end

    // Losses 2..17: counter saturates at 15.
    for (int k = 2; k <= 17; k++) begin
      LOCK = 1'b0;
      step(); step(); step();
      exp_lc = (k > 15) ? 15 : k;
      chk($sformatf("loss%0d.state", k), STATE,      2'd0);
      chk($sformatf("loss%0d.cnt", k),   LOSS_COUNT, exp_lc[3:0]);
      chk($sformatf("loss%0d.lost", k),  LOCK_LOST,  1'b1);
      LOCK = 1'b1;
      wait_run($sformatf("loss%0d.requal", k), 30);
    end

    // Clear coincident with a loss: loss wins.
    LOCK = 1'b0;
    step(); step();
    CLR_LOSS = 1'b1;
    step();
    CLR_LOSS = 1'b0;
    chk("clrloss.state", STATE,      2'd0);
    chk("clrloss.lost",  LOCK_LOST,  1'b1);
    chk("clrloss.cnt",   LOSS_COUNT, 4'd1);
    LOCK = 1'b1;
    wait_run("clrloss.requal", 30);

    // Asynchronous reset mid-run with lock held high.
    step();
    RESET_N = 1'b0;
    #2;
    chk("arst.frn",   FABRIC_RESET_N, 1'b0);
    chk("arst.state", STATE,          2'd0);
    chk("arst.sync",  LOCK_SYNC,      1'b0);
    chk("arst.ce",    CE,             2'b00);
    chk("arst.lost",  LOCK_LOST,      1'b0);
    chk("arst.cnt",   LOSS_COUNT,     4'd0);
    step(); step();
    RESET_N = 1'b1;
    for (int k = 0; k < 17; k++) step();
    chk("rel17.frn",   FABRIC_RESET_N, 1'b0);
    chk("rel17.state", STATE,          2'd1);
    step();
    chk("rel18.frn",   FABRIC_RESET_N, 1'b1);
    chk("rel18.state", STATE,          2'd2);
    chk("rel18.cnt",   LOSS_COUNT,     4'd0);

    // Plain clear after a loss.
    LOCK = 1'b0;
    step(); step(); step();
    chk("loss_b.lost", LOCK_LOST,  1'b1);
    chk("loss_b.cnt",  LOSS_COUNT, 4'd1);
    CLR_LOSS = 1'b1;
    step();
    CLR_LOSS = 1'b0;
    chk("clr.lost", LOCK_LOST,  1'b0);
    chk("clr.cnt",  LOSS_COUNT, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
